parity_checker: RTL and testbench
=================================

PARITY_CHECKER -- requirements
Module: parity_checker

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, number of data bits per frame (range 1..32).
REQ-002 SHALL provide parameter ODD, default 0, parity sense (0 = even, 1 = odd).
REQ-003 SHALL provide CLK  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL provide RST_N  input  1  reset, asynchronous and active-low.
REQ-005 SHALL provide START  input  1  frame start strobe, sampled on CLK.
REQ-006 SHALL provide BIT_EN  input  1  qualifies BIT_IN for the current cycle.
REQ-007 SHALL provide BIT_IN  input  1  serial bit from the upstream XOR/serializer stage, LSB first.
REQ-008 SHALL provide DATA  output  DATA_W  last completed frame payload.
REQ-009 SHALL provide VALID  output  1  one-cycle pulse marking frame completion.
REQ-010 SHALL provide PERR  output  1  parity error flag of last completed frame.
REQ-011 SHALL provide BUSY  output  1  high while a frame is in progress.

Function
REQ-012 SHALL implement three states: IDLE, DATA, PARITY.
REQ-013 In IDLE, START=1 SHALL move to DATA, clear the bit counter, shift register and running parity; BIT_EN/BIT_IN in that cycle SHALL be ignored.
REQ-014 In DATA, each cycle with BIT_EN=1 SHALL shift BIT_IN into bit position [count] (LSB first), XOR it into running parity, and increment count.
REQ-015 BIT_EN=0 SHALL hold all state (no shift, no count, no parity update).
REQ-016 When the DATA_W-th data bit is accepted, state SHALL move to PARITY on the same edge.
REQ-017 In PARITY, BIT_EN=1 SHALL accept BIT_IN as the parity bit and return to IDLE.
REQ-018 On the edge after the parity bit is accepted, VALID SHALL be 1 for exactly one cycle, DATA SHALL equal the assembled payload, PERR SHALL equal running_parity XOR parity_bit XOR ODD.
REQ-019 DATA and PERR SHALL update only at frame completion and hold until the next completion.
REQ-020 START=1 in DATA or PARITY SHALL abort the frame (no VALID, DATA/PERR unchanged) and restart in DATA with cleared counter/parity.
REQ-021 START=1 in the same cycle the parity bit is accepted SHALL complete the current frame (VALID pulse) and begin a new frame in DATA.
REQ-022 BUSY SHALL be 1 in DATA and PARITY, 0 in IDLE.
REQ-023 Bit counter SHALL be wide enough for DATA_W with no wrap-around within a frame.
REQ-024 Back-to-back frames SHALL be supported with no idle cycle required between parity bit and next START.

Reset
REQ-025 RST_N=0 SHALL immediately force state IDLE, DATA=0, VALID=0, PERR=0, BUSY=0, counter and running parity 0, independent of CLK.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; no VALID SHALL follow deassertion.
REQ-027 After RST_N rises, the first START SHALL be honoured on the next rising CLK edge.

Verification
REQ-028 Even parity, DATA_W=8: START, bits of 0xA5 LSB first, parity bit 0 -> one VALID pulse, DATA=0xA5, PERR=0.
REQ-029 Same frame with parity bit 1 -> VALID, DATA=0xA5, PERR=1; ODD=1 build with parity bit 1 -> PERR=0.
REQ-030 Frame 0x3C with BIT_EN toggled 0/1 every cycle -> same result as contiguous BIT_EN: DATA=0x3C, PERR=0 with parity bit 0.
REQ-031 START reasserted after 4 data bits, then full frame 0xFF parity 0 -> exactly one VALID, DATA=0xFF, PERR=0.
REQ-032 RST_N pulsed low between CLK edges after 5 bits -> outputs zero immediately, BUSY=0, no VALID until a new complete frame.
REQ-033 Two back-to-back frames 0x01 (parity 1) and 0x80 (parity 0), START coincident with first parity bit -> two VALID pulses; DATA 0x01 then 0x80; PERR 0 then 1.

Source files
------------

// File: rtl/parity_checker.sv
// Serial parity checker: assembles DATA_W bits LSB first, then checks a trailing parity bit.
// Emits a one-cycle valid pulse with the payload and the parity error flag.
module parity_checker #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bit_en,
    input  logic              bit_in,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              perr,
    output logic              busy
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n, data_n;
    logic              rpar, rpar_n, valid_n, perr_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            shreg <= '0;
            rpar  <= 1'b0;
            data  <= '0;
            valid <= 1'b0;
            perr  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            shreg <= shreg_n;
            rpar  <= rpar_n;
            data  <= data_n;
            valid <= valid_n;
            perr  <= perr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        rpar_n  = rpar;
        data_n  = data;
        perr_n  = perr;
        valid_n = 1'b0;
        case (state)
            S_DATA: begin
                if (!start && bit_en) begin
                    for (int i = 0; i < DATA_W; i++)
                        if (cnt == CNT_W'(i)) shreg_n[i] = bit_in;
                    rpar_n = rpar ^ bit_in;
                    cnt_n  = cnt + 1'b1;
                    if (cnt == LAST) state_n = S_PARITY;
                end
            end
            S_PARITY: begin
                // A parity bit coinciding with start still completes this frame.
                if (bit_en) begin
                    valid_n = 1'b1;
                    data_n  = shreg;
                    perr_n  = rpar ^ bit_in ^ ODD;
                    state_n = S_IDLE;
                end
            end
            default: ;
        endcase
        if (start) begin
            state_n = S_DATA;
            cnt_n   = '0;
            shreg_n = '0;
            rpar_n  = 1'b0;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_parity_checker.sv
// Randomized self-checking bench for parity_checker; an even and an odd build share stimulus.
// Expected payload/parity come from a frame-level model using $countones.
module tb_parity_checker;
    localparam int DATA_W = 8;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bit_en = 1'b0, bit_in = 1'b0;
    logic [DATA_W-1:0] data_e, data_o;
    logic valid_e, valid_o, perr_e, perr_o, busy_e, busy_o;

    int vectors = 0, miscompares = 0, vcount = 0;
    logic [DATA_W-1:0] exp_data = '0;
    logic              exp_perr = 1'b0;

    parity_checker #(.DATA_W(DATA_W), .ODD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_en(bit_en), .bit_in(bit_in),
        .data(data_e), .valid(valid_e), .perr(perr_e), .busy(busy_e));

    parity_checker #(.DATA_W(DATA_W), .ODD(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_en(bit_en), .bit_in(bit_in),
        .data(data_o), .valid(valid_o), .perr(perr_o), .busy(busy_o));

    always #5 clk = ~clk;

    // valid is high for a whole cycle, so each pulse is seen exactly once here
    always @(negedge clk) if (valid_e) vcount++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
        $fatal(1);
    end

    function automatic logic ref_perr(input logic [DATA_W-1:0] p, input logic pb, input bit odd);
        return logic'((($countones(p) + int'(pb)) % 2 != 0) ^ odd);
    endfunction

    task automatic cyc(input logic s, input logic e, input logic b);
        start = s; bit_en = e; bit_in = b;
        @(posedge clk); #1;
    endtask

    // gap: 0 contiguous, 1 one idle cycle before every bit, 2 random 0..2 idle cycles
    task automatic drive_bits(input logic [DATA_W-1:0] p, input int gap, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            int idles = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(2, 0)) : 0;
            for (int k = 0; k < idles; k++) cyc(1'b0, 1'b0, 1'($urandom));
            cyc(1'b0, 1'b1, p[i]);
        end
    endtask

    task automatic test_reset;
        #2;
        vectors++; if (data_e !== '0 || data_o !== '0) begin miscompares++;
            $display("FAIL reset_data: got %h/%h expected 00", data_e, data_o); end
        vectors++; if ({valid_e, perr_e, busy_e, valid_o, perr_o, busy_o} !== 6'b0) begin miscompares++;
            $display("FAIL reset_flags: got %b expected 000000", {valid_e, perr_e, busy_e, valid_o, perr_o, busy_o}); end
        @(negedge clk) rst_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b1);
        vectors++; if (busy_e !== 1'b0) begin miscompares++;
            $display("FAIL idle_ignores_bits: busy got %b expected 0", busy_e); end
    endtask

    task automatic test_basic(input logic [DATA_W-1:0] p, input logic pb, input int gap, input string name);
        int v0 = vcount;
        cyc(1'b1, 1'b0, 1'b1);
        vectors++; if (busy_e !== 1'b1) begin miscompares++;
            $display("FAIL %s_busy: got %b expected 1", name, busy_e); end
        drive_bits(p, gap, DATA_W);
        cyc(1'b0, 1'b1, pb);
        exp_data = p; exp_perr = ref_perr(p, pb, 1'b0);
        vectors++; if (valid_e !== 1'b1 || data_e !== exp_data) begin miscompares++;
            $display("FAIL %s_done: valid %b data %h expected 1 %h", name, valid_e, data_e, exp_data); end
        vectors++; if (perr_e !== exp_perr || perr_o !== ref_perr(p, pb, 1'b1)) begin miscompares++;
            $display("FAIL %s_perr: got even %b odd %b expected %b %b", name, perr_e, perr_o, exp_perr, ref_perr(p, pb, 1'b1)); end
        cyc(1'b0, 1'b0, 1'b1);
        vectors++; if (valid_e !== 1'b0 || data_e !== exp_data || perr_e !== exp_perr || busy_e !== 1'b0) begin miscompares++;
            $display("FAIL %s_hold: valid %b data %h perr %b busy %b expected 0 %h %b 0", name, valid_e, data_e, perr_e, busy_e, exp_data, exp_perr); end
        vectors++; if (vcount - v0 !== 1) begin miscompares++;
            $display("FAIL %s_pulses: got %0d expected 1", name, vcount - v0); end
    endtask

    task automatic test_abort;
        int v0 = vcount;
        cyc(1'b1, 1'b0, 1'b0);
        drive_bits(8'($urandom), 0, 4);
        cyc(1'b1, 1'b1, 1'b1);
        vectors++; if (busy_e !== 1'b1 || valid_e !== 1'b0 || data_e !== exp_data || perr_e !== exp_perr) begin miscompares++;
            $display("FAIL abort_hold: busy %b valid %b data %h perr %b expected 1 0 %h %b", busy_e, valid_e, data_e, perr_e, exp_data, exp_perr); end
        drive_bits(8'hFF, 0, DATA_W);
        cyc(1'b0, 1'b1, 1'b0);
        exp_data = 8'hFF; exp_perr = 1'b0;
        vectors++; if (valid_e !== 1'b1 || data_e !== 8'hFF || perr_e !== 1'b0 || perr_o !== 1'b1) begin miscompares++;
            $display("FAIL abort_frame: valid %b data %h perr %b/%b expected 1 ff 0/1", valid_e, data_e, perr_e, perr_o); end
        cyc(1'b0, 1'b0, 1'b0);
        vectors++; if (vcount - v0 !== 1) begin miscompares++;
            $display("FAIL abort_pulses: got %0d expected 1", vcount - v0); end
    endtask

    task automatic test_async_reset;
        int v0;
        cyc(1'b1, 1'b0, 1'b0);
        drive_bits(8'($urandom), 0, 5);
        #3 rst_n = 1'b0;
        #1;
        vectors++; if (data_e !== '0 || {valid_e, perr_e, busy_e, busy_o, perr_o} !== 5'b0) begin miscompares++;
            $display("FAIL async_reset: data %h valid %b perr %b busy %b expected 00 0 0 0", data_e, valid_e, perr_e, busy_e); end
        exp_data = '0; exp_perr = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        v0 = vcount;
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'($urandom));
        vectors++; if (vcount !== v0 || busy_e !== 1'b0 || data_e !== '0) begin miscompares++;
            $display("FAIL reset_no_valid: pulses %0d busy %b data %h expected 0 0 00", vcount - v0, busy_e, data_e); end
        test_basic(8'($urandom), 1'($urandom), 0, "post_reset");
    endtask

    task automatic test_back_to_back;
        int v0 = vcount;
        cyc(1'b1, 1'b0, 1'b0);
        drive_bits(8'h01, 0, DATA_W);
        cyc(1'b1, 1'b1, 1'b1);
        vectors++; if (valid_e !== 1'b1 || data_e !== 8'h01 || perr_e !== 1'b0 || busy_e !== 1'b1) begin miscompares++;
            $display("FAIL b2b_first: valid %b data %h perr %b busy %b expected 1 01 0 1", valid_e, data_e, perr_e, busy_e); end
        drive_bits(8'h80, 0, DATA_W);
        cyc(1'b0, 1'b1, 1'b0);
        vectors++; if (valid_e !== 1'b1 || data_e !== 8'h80 || perr_e !== 1'b1 || busy_e !== 1'b0) begin miscompares++;
            $display("FAIL b2b_second: valid %b data %h perr %b busy %b expected 1 80 1 0", valid_e, data_e, perr_e, busy_e); end
        exp_data = 8'h80; exp_perr = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        vectors++; if (vcount - v0 !== 2) begin miscompares++;
            $display("FAIL b2b_pulses: got %0d expected 2", vcount - v0); end
    endtask

    task automatic test_random(input int n);
        logic chained = 1'b0;
        for (int f = 0; f < n; f++) begin
            logic [DATA_W-1:0] p  = DATA_W'($urandom);
            logic              pb = 1'($urandom);
            logic              nx = (f < n - 1) && ($urandom_range(3, 0) == 0);
            if (!chained) cyc(1'b1, 1'b0, 1'($urandom));
            if ($urandom_range(4, 0) == 0) begin
                drive_bits(DATA_W'($urandom), 2, int'($urandom_range(DATA_W - 1, 1)));
                cyc(1'b1, 1'b0, 1'b0);
            end
            drive_bits(p, 2, DATA_W);
            for (int k = 0; k < int'($urandom_range(2, 0)); k++) cyc(1'b0, 1'b0, 1'($urandom));
            cyc(nx, 1'b1, pb);
            exp_data = p; exp_perr = ref_perr(p, pb, 1'b0);
            vectors++; if (valid_e !== 1'b1 || data_e !== exp_data || perr_e !== exp_perr || perr_o !== ~exp_perr || busy_e !== nx) begin miscompares++;
                $display("FAIL rand_frame%0d: valid %b data %h perr %b/%b busy %b expected 1 %h %b/%b %b",
                         f, valid_e, data_e, perr_e, perr_o, busy_e, exp_data, exp_perr, ~exp_perr, nx); end
            chained = nx;
        end
        cyc(1'b0, 1'b0, 1'b0);
        vectors++; if (valid_e !== 1'b0 || data_e !== exp_data) begin miscompares++;
            $display("FAIL rand_tail: valid %b data %h expected 0 %h", valid_e, data_e, exp_data); end
    endtask

    initial begin
        test_reset();
        test_basic(8'hA5, 1'b0, 0, "a5_p0");
        test_basic(8'hA5, 1'b1, 0, "a5_p1");
        test_basic(8'h3C, 1'b0, 1, "3c_gapped");
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_random(40);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
